// File: rtl/gpio_port.sv
// -----------------------------------------------------------------------------
// gpio_port : parametrised GPIO port between the register file and the pad ring.
//   - per-pin output latch driven by set/clear/toggle pulses (clr > set > tgl)
//   - per-pin mode: input, push-pull, open-drain, hold
//   - SYNC_STAGES-deep input synchroniser feeding r_id
//   - rise/fall/both/level triggers, sticky W1C pending, enable mask, IRQ
//   - arm FSM that suppresses the false edge seen while the synchroniser fills
// Optional feature macro: GPIO_DEBOUNCE_EN adds a per-pin debounce filter with
// threshold r_db_div between the synchroniser and the edge detector.
// -----------------------------------------------------------------------------
module gpio_port #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 8
) (
    input  logic                  module_clk,
    input  logic                  module_rst,
    input  logic [2*WIDTH-1:0]    r_mode,
    input  logic [WIDTH-1:0]      r_out_set,
    input  logic [WIDTH-1:0]      r_out_clr,
    input  logic [WIDTH-1:0]      r_out_tgl,
    input  logic [2*WIDTH-1:0]    r_inttrig,
    input  logic [WIDTH-1:0]      r_inten,
    input  logic [WIDTH-1:0]      r_intclr,
    input  logic [DB_CNT_W-1:0]   r_db_div,
    output logic [WIDTH-1:0]      r_id,
    output logic [WIDTH-1:0]      r_intpend,
    output logic [WIDTH-1:0]      gpio_out,
    output logic [WIDTH-1:0]      gpio_dir,
    input  logic [WIDTH-1:0]      gpio_in,
    output logic [WIDTH-1:0]      gpio_int,
    output logic                  gpio_irq
);

    // Pin modes
    localparam logic [1:0] MODE_IN   = 2'b00;
    localparam logic [1:0] MODE_PP   = 2'b01;
    localparam logic [1:0] MODE_OD   = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Trigger kinds
    localparam logic [1:0] TRIG_RISE  = 2'b00;
    localparam logic [1:0] TRIG_FALL  = 2'b01;
    localparam logic [1:0] TRIG_BOTH  = 2'b10;
    localparam logic [1:0] TRIG_LEVEL = 2'b11;

    // Arm FSM states
    localparam logic [0:0] ST_DISARMED = 1'b0;
    localparam logic [0:0] ST_ARMED    = 1'b1;

    // Arm counter is wide enough for SYNC_STAGES plus the largest debounce delay
    localparam int ARM_W = DB_CNT_W + 8;

    logic [WIDTH-1:0]                  out_latch_r;
    logic [WIDTH-1:0]                  gpio_out_r;
    logic [WIDTH-1:0]                  gpio_dir_r;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]                  sync_s;
    logic [WIDTH-1:0]                  filt_s;
    logic [WIDTH-1:0]                  prev_r;
    logic [WIDTH-1:0]                  id_r;
    logic [WIDTH-1:0]                  intpend_r;
    logic                              irq_r;
    logic [WIDTH-1:0]                  event_s;
    logic [0:0]                        arm_state_r;
    logic [ARM_W-1:0]                  arm_cnt_r;
    logic [ARM_W-1:0]                  arm_tgt_s;

    // Output latch: clear beats set beats toggle, updated in every pin mode
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            out_latch_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_out_clr[i]) begin
                    out_latch_r[i] <= 1'b0;
                end else if (r_out_set[i]) begin
                    out_latch_r[i] <= 1'b1;
                end else if (r_out_tgl[i]) begin
                    out_latch_r[i] <= ~out_latch_r[i];
                end else begin
                    out_latch_r[i] <= out_latch_r[i];
                end
            end
        end
    end

    // Pad drive: open-drain pulls low by enabling the driver with a 0 value
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            gpio_out_r <= {WIDTH{1'b0}};
            gpio_dir_r <= {WIDTH{1'b1}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case (r_mode[2*i +: 2])
                    MODE_IN: begin
                        gpio_dir_r[i] <= 1'b0;
                        gpio_out_r[i] <= out_latch_r[i];
                    end
                    MODE_PP: begin
                        gpio_dir_r[i] <= 1'b1;
                        gpio_out_r[i] <= out_latch_r[i];
                    end
                    MODE_OD: begin
                        gpio_dir_r[i] <= ~out_latch_r[i];
                        gpio_out_r[i] <= 1'b0;
                    end
                    MODE_HOLD: begin
                        gpio_dir_r[i] <= gpio_dir_r[i];
                        gpio_out_r[i] <= gpio_out_r[i];
                    end
                    default: begin
                        gpio_dir_r[i] <= gpio_dir_r[i];
                        gpio_out_r[i] <= gpio_out_r[i];
                    end
                endcase
            end
        end
    end

    // Input synchroniser chain for the asynchronous pad inputs
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
        end else begin
            sync_r[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [WIDTH-1:0][DB_CNT_W-1:0] db_cnt_r;
    logic [WIDTH-1:0]               filt_r;

    // Debounce: a new level must persist r_db_div+1 cycles before it is accepted
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            db_cnt_r <= {(WIDTH*DB_CNT_W){1'b0}};
            filt_r   <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s[i] != filt_r[i]) begin
                    if (db_cnt_r[i] == r_db_div) begin
                        filt_r[i]   <= sync_s[i];
                        db_cnt_r[i] <= {DB_CNT_W{1'b0}};
                    end else begin
                        filt_r[i]   <= filt_r[i];
                        db_cnt_r[i] <= db_cnt_r[i] + DB_CNT_W'(1);
                    end
                end else begin
                    filt_r[i]   <= filt_r[i];
                    db_cnt_r[i] <= {DB_CNT_W{1'b0}};
                end
            end
        end
    end

    assign filt_s    = filt_r;
    assign arm_tgt_s = ARM_W'(SYNC_STAGES) + ARM_W'(r_db_div) + ARM_W'(1);
`else
    logic unused_db_div_s;

    assign unused_db_div_s = ^r_db_div;
    assign filt_s          = sync_s;
    assign arm_tgt_s       = ARM_W'(SYNC_STAGES);
`endif

    // Filtered data register and one-cycle-delayed copy for edge detection
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            id_r   <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            id_r   <= filt_s;
            prev_r <= filt_s;
        end
    end

    // Arm FSM: wait until the input pipeline holds real pad data after reset
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            arm_state_r <= ST_DISARMED;
            arm_cnt_r   <= {ARM_W{1'b0}};
        end else begin
            case (arm_state_r)
                ST_DISARMED: begin
                    if (arm_cnt_r >= arm_tgt_s) begin
                        arm_state_r <= ST_ARMED;
                        arm_cnt_r   <= arm_cnt_r;
                    end else begin
                        arm_state_r <= ST_DISARMED;
                        arm_cnt_r   <= arm_cnt_r + ARM_W'(1);
                    end
                end
                ST_ARMED: begin
                    arm_state_r <= ST_ARMED;
                    arm_cnt_r   <= arm_cnt_r;
                end
                default: begin
                    arm_state_r <= ST_DISARMED;
                    arm_cnt_r   <= {ARM_W{1'b0}};
                end
            endcase
        end
    end

    // Per-pin trigger decode; only input-mode pins raise events once armed
    always_comb begin
        event_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if ((arm_state_r == ST_ARMED) && (r_mode[2*i +: 2] == MODE_IN)) begin
                case (r_inttrig[2*i +: 2])
                    TRIG_RISE:  event_s[i] = filt_s[i] & ~prev_r[i];
                    TRIG_FALL:  event_s[i] = ~filt_s[i] & prev_r[i];
                    TRIG_BOTH:  event_s[i] = filt_s[i] ^ prev_r[i];
                    TRIG_LEVEL: event_s[i] = filt_s[i];
                    default:    event_s[i] = 1'b0;
                endcase
            end else begin
                event_s[i] = 1'b0;
            end
        end
    end

    // Sticky pending: a new event wins over a coincident clear
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            intpend_r <= {WIDTH{1'b0}};
        end else begin
            intpend_r <= (intpend_r & ~r_intclr) | event_s;
        end
    end

    // Registered interrupt request from the enabled pending bits
    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(intpend_r & r_inten);
        end
    end

    assign r_id      = id_r;
    assign r_intpend = intpend_r;
    assign gpio_out  = gpio_out_r;
    assign gpio_dir  = gpio_dir_r;
    assign gpio_int  = intpend_r & r_inten;
    assign gpio_irq  = irq_r;

endmodule
